fetch_stage: RTL

Instruction-fetch stage feeding the IF/ID register that the opcode decoder/control unit consumes. Holds the PC, issues requests to instruction memory with a ready handshake, and applies branch redirects from the branch unit. Fetch stops after an HLT (opcode 4'hF) is fetched. Drives the IF/ID pipeline register, including bubbles.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch_pc_reg.sv | 30 +++
 rtl/fetch_stage.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, NOP encoding, fetch FSM states
// and default datapath widths.
package cpu_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int INSTR_W_DEF = 16;

  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [15:0] INSTR_NOP = 16'h0000;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: async reset, redirect load,
// increment by 2 (wrapping), otherwise hold.
module fetch_pc_reg
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus2
);

  assign pc_plus2 = pc + ADDR_W'(2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc_plus2;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage driving the IF/ID register.
// Optional perf counters enabled by FETCH_PERF_CNT_EN.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc_plus2,
  output logic               if_id_valid,
  output logic               fetch_halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall_cycles
`endif
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus2;
  logic [ADDR_W-1:0] target;
  logic              in_fetch;
  logic              is_hlt;
  logic              do_redir;
  logic              do_hold;
  logic              do_load;
  logic              do_inc;

  assign target   = {branch_target[ADDR_W-1:1], 1'b0};
  assign in_fetch = (state == FETCH);
  assign is_hlt   = (imem_data[INSTR_W-1 -: 4] == OP_HLT);

  // Mutually exclusive so the decoder below can be unique.
  assign do_redir = branch_taken;
  assign do_hold  = stall & ~branch_taken;
  assign do_load  = ~branch_taken & ~stall
                  & in_fetch & imem_ready;
  assign do_inc   = do_load & ~is_hlt;

  assign imem_req  = in_fetch & ~rst;
  assign imem_addr = pc;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (do_redir),
    .inc      (do_inc),
    .target   (target),
    .pc       (pc),
    .pc_plus2 (pc_plus2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= FETCH;
      if_id_instr    <= INSTR_W'(INSTR_NOP);
      if_id_pc_plus2 <= '0;
      if_id_valid    <= 1'b0;
      fetch_halted   <= 1'b0;
    end else begin
      unique case (1'b1)
        do_redir: begin
          state          <= FETCH;
          fetch_halted   <= 1'b0;
          if_id_instr    <= INSTR_W'(INSTR_NOP);
          if_id_pc_plus2 <= '0;
          if_id_valid    <= 1'b0;
        end
        do_hold: ;
        do_load: begin
          if_id_instr    <= imem_data;
          if_id_pc_plus2 <= pc_plus2;
          if_id_valid    <= 1'b1;
          if (is_hlt) begin
            state        <= HALTED;
            fetch_halted <= 1'b1;
          end
        end
        default: begin
          if_id_instr    <= INSTR_W'(INSTR_NOP);
          if_id_pc_plus2 <= '0;
          if_id_valid    <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic stall_cyc;

  assign stall_cyc = in_fetch & (stall | ~imem_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched      <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (do_load && perf_fetched != 32'hFFFF_FFFF)
        perf_fetched <= perf_fetched + 32'd1;
      if (stall_cyc && perf_stall_cycles != 32'hFFFF_FFFF)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
